seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Registered 8-bit signed ALU: performs ADD, SUB, MULT or DIV on two operands and registers the result on the rising clock edge.
- Used as a leaf datapath block; the result is valid one cycle after its operands and opcode are presented.
- No handshake: one operation is issued every cycle.

Parameters:
- WIDTH, 8, operand/result width in bits (two's-complement signed); all behaviour below is stated for 8.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- opcode  input  2  operation select, type opcode_e.
- operand1  input  WIDTH  signed first operand (dividend/minuend).
- operand2  input  WIDTH  signed second operand (divisor/subtrahend).
- out  output  WIDTH  signed registered result.

Behaviour:
- Reset:
  - rst=0 clears out to 0 immediately, without waiting for a clock edge.
  - out holds 0 for every edge while rst=0.
  - First computed result appears on the first rising edge after rst returns to 1.
- Latency: one cycle. out at posedge N is computed from opcode/operands sampled at posedge N. Inputs are combinational into the register; no input pipeline.
- Throughput: new operation every cycle; out updates every cycle; no enable input.
- Operations (all signed, result truncated to the low WIDTH bits, i.e. wrap-around):
  - ADD (2'b00): operand1 + operand2. Example: 127 + 1 -> -128.
  - SUB (2'b01): operand1 - operand2. Example: -128 - 1 -> 127.
  - MULT (2'b10): low WIDTH bits of the full 2*WIDTH signed product. Example: 16 * 16 -> 0; -3 * 5 -> -15.
  - DIV (2'b11): signed quotient, truncated toward zero, remainder discarded. Examples: -7 / 2 -> -3; 7 / -2 -> -3.
- DIV boundaries:
  - Divisor 0 -> out = 0. The value is defined; no X may propagate.
  - -128 / -1 -> -128 (wrap).
- Undefined opcode values (X/Z in simulation) -> out = 0.
- Reset asserted mid-operation: the in-flight result is discarded and out = 0. The first post-reset result reflects only inputs sampled after deassertion.

Optional Feature:
- Macro: SEQ_ALU_STATUS_EN.
- Defined: adds two registered outputs with the same latency and reset value as out:
  - ovf (1): set when the true mathematical result does not fit in WIDTH signed bits (ADD/SUB overflow, MULT product out of range, DIV -128/-1).
  - dz (1): set when opcode=DIV and operand2=0.
  - Both clear to 0 under reset.
- Undefined: ports ovf and dz do not exist; out behaviour is identical in both builds.

Decomposition:
- Shared package seq_alu_pkg:
  - typedef enum logic [1:0] opcode_e {ADD=0, SUB=1, MULT=2, DIV=3}.
  - WIDTH default constant.
- Sub-module seq_alu_div: combinational signed divider.
  - Inputs: dividend, divisor.
  - Outputs: quotient, div_by_zero.
  - Truncate-toward-zero semantics and zero-divisor result (0) are encapsulated here.
- Top level holds the opcode mux, overflow detection and the output register.

Test Plan:
- Reset: rst=0 with operands 5, 3, ADD -> out=0 immediately and on every clock. Release rst -> out=8 after the next posedge.
- Arithmetic sweep: ADD 100+27=127, SUB 3-10=-7, MULT -3*5=-15, DIV -7/2=-3, each checked exactly one cycle after applying the inputs.
- Wrap: ADD 127+1=-128; SUB -128-1=127; MULT 16*16=0; DIV -128/-1=-128. With SEQ_ALU_STATUS_EN, ovf=1 on each.
- Divide by zero: DIV 42/0 -> out=0; with SEQ_ALU_STATUS_EN, dz=1 and ovf=0. A following DIV 42/6 -> out=7, dz=0.
- Back-to-back: change opcode/operands every cycle for 50000 random cycles. out each cycle matches a signed 8-bit golden model of the previous cycle's inputs; zero mismatches.
- Mid-stream reset: assert rst=0 asynchronously between edges during a MULT stream -> out=0 before the next edge. After release, results resume with one-cycle latency.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the registered signed ALU.
// Optional status outputs (ovf, dz) are enabled by defining SEQ_ALU_STATUS_EN.
package seq_alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ADD  = 2'd0,
        SUB  = 2'd1,
        MULT = 2'd2,
        DIV  = 2'd3
    } opcode_e;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result bundle of seq_alu; the master issues one operation per cycle.
// ovf/dz exist only when SEQ_ALU_STATUS_EN is defined.
interface seq_alu_if #(
    parameter int WIDTH = seq_alu_pkg::DEFAULT_WIDTH
);
    import seq_alu_pkg::*;

    opcode_e                 opcode;
    logic signed [WIDTH-1:0] operand1;
    logic signed [WIDTH-1:0] operand2;
    logic signed [WIDTH-1:0] out;
`ifdef SEQ_ALU_STATUS_EN
    logic                    ovf;
    logic                    dz;

    modport master (output opcode, operand1, operand2, input  out, ovf, dz);
    modport slave  (input  opcode, operand1, operand2, output out, ovf, dz);
`else
    modport master (output opcode, operand1, operand2, input  out);
    modport slave  (input  opcode, operand1, operand2, output out);
`endif

endinterface

// File: rtl/seq_alu_div.sv
// Combinational signed divider: quotient truncates toward zero, and a zero
// divisor yields a quotient of 0 with div_by_zero flagged.
module seq_alu_div #(
    parameter int WIDTH = seq_alu_pkg::DEFAULT_WIDTH
) (
    input  logic signed [WIDTH-1:0] dividend,
    input  logic signed [WIDTH-1:0] divisor,
    output logic signed [WIDTH-1:0] quotient,
    output logic                    div_by_zero
);

    assign div_by_zero = (divisor == '0);

    // NOTE: assign the default first so every path through the block drives quotient; no latch.
    always_comb begin
        quotient = '0;
        if (!div_by_zero) begin
            quotient = dividend / divisor;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered signed ALU (ADD/SUB/MULT/DIV), one-cycle latency, wrap-around results.
// Define SEQ_ALU_STATUS_EN to add registered ovf/dz status outputs.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);

    logic signed [WIDTH-1:0]   a, b;
    logic signed [WIDTH-1:0]   sum, diff, quotient;
    logic signed [2*WIDTH-1:0] product;
    logic                      div_by_zero;
    logic signed [WIDTH-1:0]   out_d, out_q;

    assign a       = bus.operand1;
    assign b       = bus.operand2;
    assign sum     = a + b;
    assign diff    = a - b;
    assign product = a * b;

    seq_alu_div #(.WIDTH(WIDTH)) u_div (
        .dividend    (a),
        .divisor     (b),
        .quotient    (quotient),
        .div_by_zero (div_by_zero)
    );

    // Unknown opcodes fall into default and produce 0.
    always_comb begin
        out_d = '0;
        case (bus.opcode)
            ADD:     out_d = sum;
            SUB:     out_d = diff;
            MULT:    out_d = product[WIDTH-1:0];
            DIV:     out_d = div_by_zero ? '0 : quotient;
            default: out_d = '0;
        endcase
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;

`ifdef SEQ_ALU_STATUS_EN
    logic ovf_d, dz_d;
    logic ovf_q, dz_q;

    // Product fits only if its upper half is a sign extension of bit WIDTH-1.
    always_comb begin
        ovf_d = 1'b0;
        dz_d  = 1'b0;
        case (bus.opcode)
            ADD:     ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            SUB:     ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            MULT:    ovf_d = (product[2*WIDTH-1:WIDTH-1] != '0) &&
                             (product[2*WIDTH-1:WIDTH-1] != '1);
            DIV: begin
                dz_d  = div_by_zero;
                ovf_d = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            dz_q  <= dz_d;
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.dz  = dz_q;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus a random stream against
// an integer reference model. Status outputs checked when SEQ_ALU_STATUS_EN is defined.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_alu_if bus_if ();

    seq_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, then wrap to 8 bits.
    function automatic void ref_model(input opcode_e op, input int x, input int y,
                                      output logic signed [7:0] r, output bit ovf, output bit dz);
        int t;
        t   = 0;
        dz  = 1'b0;
        case (op)
            ADD:  t = x + y;
            SUB:  t = x - y;
            MULT: t = x * y;
            DIV: begin
                if (y == 0) begin
                    dz = 1'b1;
                    t  = 0;
                end else begin
                    t = x / y;
                end
            end
            default: t = 0;
        endcase
        ovf = (t < -128) || (t > 127);
        r   = 8'(t);
    endfunction

    task automatic drive(input opcode_e op, input logic signed [7:0] x, input logic signed [7:0] y);
        bus_if.opcode   = op;
        bus_if.operand1 = x;
        bus_if.operand2 = y;
    endtask

    // Present inputs after a falling edge, return 1 time unit after the capturing rising edge.
    task automatic cycle(input opcode_e op, input logic signed [7:0] x, input logic signed [7:0] y);
        @(negedge clk);
        drive(op, x, y);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(ADD, 8'sd5, 8'sd3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus_if.out !== 8'sd0) begin
            errors++;
            $display("FAIL reset_async out=%0d expected=0", bus_if.out);
        end
`ifdef SEQ_ALU_STATUS_EN
        checks++;
        if (bus_if.ovf !== 1'b0 || bus_if.dz !== 1'b0) begin
            errors++;
            $display("FAIL reset_status ovf=%b dz=%b expected 0 0", bus_if.ovf, bus_if.dz);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus_if.out !== 8'sd0) begin
                errors++;
                $display("FAIL reset_hold[%0d] out=%0d expected=0", i, bus_if.out);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.out !== 8'sd8) begin
            errors++;
            $display("FAIL reset_release out=%0d expected=8", bus_if.out);
        end
    endtask

    typedef struct {
        opcode_e           op;
        logic signed [7:0] x;
        logic signed [7:0] y;
        logic signed [7:0] exp_out;
        bit                exp_ovf;
        bit                exp_dz;
    } vec_t;

    task automatic test_directed();
        vec_t v[10];
        v[0] = '{ADD,  8'sd100,  8'sd27,  8'sd127,  1'b0, 1'b0};
        v[1] = '{SUB,  8'sd3,    8'sd10, -8'sd7,    1'b0, 1'b0};
        v[2] = '{MULT, -8'sd3,   8'sd5,  -8'sd15,   1'b0, 1'b0};
        v[3] = '{DIV,  -8'sd7,   8'sd2,  -8'sd3,    1'b0, 1'b0};
        v[4] = '{DIV,  8'sd7,   -8'sd2,  -8'sd3,    1'b0, 1'b0};
        v[5] = '{ADD,  8'sd127,  8'sd1,  -8'sd128,  1'b1, 1'b0};
        v[6] = '{SUB,  -8'sd128, 8'sd1,   8'sd127,  1'b1, 1'b0};
        v[7] = '{MULT, 8'sd16,   8'sd16,  8'sd0,    1'b1, 1'b0};
        v[8] = '{DIV,  -8'sd128, -8'sd1, -8'sd128,  1'b1, 1'b0};
        v[9] = '{DIV,  8'sd42,   8'sd0,   8'sd0,    1'b0, 1'b1};
        foreach (v[i]) begin
            cycle(v[i].op, v[i].x, v[i].y);
            checks++;
            if (bus_if.out !== v[i].exp_out) begin
                errors++;
                $display("FAIL directed[%0d] %s %0d,%0d out=%0d expected=%0d",
                         i, v[i].op.name(), v[i].x, v[i].y, bus_if.out, v[i].exp_out);
            end
`ifdef SEQ_ALU_STATUS_EN
            checks++;
            if (bus_if.ovf !== v[i].exp_ovf || bus_if.dz !== v[i].exp_dz) begin
                errors++;
                $display("FAIL directed_status[%0d] ovf=%b dz=%b expected ovf=%b dz=%b",
                         i, bus_if.ovf, bus_if.dz, v[i].exp_ovf, v[i].exp_dz);
            end
`endif
        end
        // A valid divide right after a divide-by-zero must clear the flag.
        cycle(DIV, 8'sd42, 8'sd6);
        checks++;
        if (bus_if.out !== 8'sd7) begin
            errors++;
            $display("FAIL div_after_zero out=%0d expected=7", bus_if.out);
        end
`ifdef SEQ_ALU_STATUS_EN
        checks++;
        if (bus_if.dz !== 1'b0) begin
            errors++;
            $display("FAIL div_after_zero_dz dz=%b expected=0", bus_if.dz);
        end
`endif
    endtask

    task automatic test_back_to_back();
        opcode_e           op;
        logic signed [7:0] x, y, r;
        bit                ovf, dz;
        int                fails_shown;
        fails_shown = 0;
        for (int n = 0; n < 50000; n++) begin
            op = opcode_e'($urandom_range(0, 3));
            x  = 8'($urandom);
            y  = ($urandom_range(0, 15) == 0) ? 8'sd0 : 8'($urandom);
            ref_model(op, int'(x), int'(y), r, ovf, dz);
            cycle(op, x, y);
            checks++;
            if (bus_if.out !== r) begin
                errors++;
                if (fails_shown < 20) begin
                    fails_shown++;
                    $display("FAIL random[%0d] %s %0d,%0d out=%0d expected=%0d",
                             n, op.name(), x, y, bus_if.out, r);
                end
            end
`ifdef SEQ_ALU_STATUS_EN
            checks++;
            if (bus_if.ovf !== ovf || bus_if.dz !== dz) begin
                errors++;
                if (fails_shown < 20) begin
                    fails_shown++;
                    $display("FAIL random_status[%0d] %s %0d,%0d ovf=%b dz=%b expected ovf=%b dz=%b",
                             n, op.name(), x, y, bus_if.ovf, bus_if.dz, ovf, dz);
                end
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        logic signed [7:0] x, y, r;
        bit                ovf, dz;
        for (int i = 0; i < 4; i++) begin
            x = 8'sd3 + 8'(i);
            y = -8'sd7;
            ref_model(MULT, int'(x), int'(y), r, ovf, dz);
            cycle(MULT, x, y);
            checks++;
            if (bus_if.out !== r) begin
                errors++;
                $display("FAIL mult_stream[%0d] out=%0d expected=%0d", i, bus_if.out, r);
            end
        end
        @(negedge clk);
        drive(MULT, 8'sd9, 8'sd9);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus_if.out !== 8'sd0) begin
            errors++;
            $display("FAIL mid_reset_async out=%0d expected=0", bus_if.out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.out !== 8'sd0) begin
            errors++;
            $display("FAIL mid_reset_hold out=%0d expected=0", bus_if.out);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(MULT, -8'sd6, 8'sd11);
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.out !== -8'sd66) begin
            errors++;
            $display("FAIL mid_reset_resume out=%0d expected=-66", bus_if.out);
        end
        cycle(MULT, 8'sd12, 8'sd12);
        checks++;
        if (bus_if.out !== -8'sd112) begin
            errors++;
            $display("FAIL mid_reset_next out=%0d expected=-112", bus_if.out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(ADD, 8'sd0, 8'sd0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
